// File: rtl/fre_offset_est.sv
// Coarse CFO estimator: sliding delayed autocorrelation P = sum r[n-k]*conj(r[n-k-D]) over a
// window of WIN samples, released once per frame while samples pass through to the compensator.
module fre_offset_est #(
   parameter int unsigned DLY     = 16,
   parameter int unsigned WIN     = 16,
   parameter int unsigned LOG2WIN = 4,
   parameter int unsigned EST_POS = 128
) (
   input  logic        CLK_I,
   input  logic        RST_I,
   input  logic [31:0] DAT_I,
   input  logic        WE_I,
   input  logic        STB_I,
   input  logic        CYC_I,
   output logic        ACK_O,
   output logic [31:0] DAT_O,
   output logic        CYC_O,
   output logic        STB_O,
   output logic        WE_O,
   input  logic        ACK_I,
   output logic [31:0] FRE_O,
   output logic        FRE_O_nd
);

   localparam int unsigned CntW = $clog2(EST_POS + 1);
   localparam int unsigned AccW = 33 + LOG2WIN;

   typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              emit;
   logic              halt, acc;

   logic [31:0]       sdl_q [DLY];
   logic [32:0]       pdl_re_q [WIN];
   logic [32:0]       pdl_im_q [WIN];
   logic [AccW-1:0]   acc_re_q, acc_im_q, acc_re_d, acc_im_d;

   logic [31:0]       dat_q, fre_q;
   logic              stb_q, cyc_q, fre_nd_q;

   logic signed [15:0] a, b, c, d;
   logic signed [31:0] ac, bd, bc, ad;
   logic [32:0]        prod_re, prod_im, old_re, old_im;

   assign halt  = stb_q & ~ACK_I;
   assign acc   = CYC_I & STB_I & WE_I & ~halt;
   assign ACK_O = acc;

   // r = a + jb is the new sample, s = c + jd the sample DLY accepted samples earlier
   assign a  = DAT_I[15:0];
   assign b  = DAT_I[31:16];
   assign c  = sdl_q[DLY-1][15:0];
   assign d  = sdl_q[DLY-1][31:16];
   assign ac = a * c;
   assign bd = b * d;
   assign bc = b * c;
   assign ad = a * d;

   assign prod_re = {ac[31], ac} + {bd[31], bd};
   assign prod_im = {bc[31], bc} - {ad[31], ad};
   assign old_re  = pdl_re_q[WIN-1];
   assign old_im  = pdl_im_q[WIN-1];

   assign acc_re_d = acc_re_q + {{LOG2WIN{prod_re[32]}}, prod_re}
                              - {{LOG2WIN{old_re[32]}}, old_re};
   assign acc_im_d = acc_im_q + {{LOG2WIN{prod_im[32]}}, prod_im}
                              - {{LOG2WIN{old_im[32]}}, old_im};

   // Window mean bits [32:16] are acc[AccW-1 -: 17]; clamp the 3.14 value to 2.14
   function automatic logic [15:0] sat(input logic [AccW-1:0] v);
      logic [16:0] q;
      q = v[AccW-1 -: 17];
      if (!q[16] && q[15])      return 16'h7FFF;
      else if (q[16] && !q[15]) return 16'h8000;
      else                      return q[15:0];
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      emit    = 1'b0;
      if (!CYC_I) begin
         state_d = StIdle;
         cnt_d   = '0;
      end else if (acc && state_q != StDone) begin
         cnt_d = cnt_q + CntW'(1);
         if (cnt_d == CntW'(EST_POS)) begin
            emit    = 1'b1;
            state_d = StDone;
         end else begin
            state_d = StFill;
         end
      end
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         for (int i = 0; i < int'(DLY); i++) sdl_q[i] <= '0;
         for (int i = 0; i < int'(WIN); i++) begin
            pdl_re_q[i] <= '0;
            pdl_im_q[i] <= '0;
         end
         acc_re_q <= '0;
         acc_im_q <= '0;
         fre_q    <= '0;
         fre_nd_q <= 1'b0;
      end else begin
         if (!CYC_I) begin
            for (int i = 0; i < int'(DLY); i++) sdl_q[i] <= '0;
            for (int i = 0; i < int'(WIN); i++) begin
               pdl_re_q[i] <= '0;
               pdl_im_q[i] <= '0;
            end
            acc_re_q <= '0;
            acc_im_q <= '0;
         end else if (acc) begin
            sdl_q[0]    <= DAT_I;
            pdl_re_q[0] <= prod_re;
            pdl_im_q[0] <= prod_im;
            for (int i = 1; i < int'(DLY); i++) sdl_q[i] <= sdl_q[i-1];
            for (int i = 1; i < int'(WIN); i++) begin
               pdl_re_q[i] <= pdl_re_q[i-1];
               pdl_im_q[i] <= pdl_im_q[i-1];
            end
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
         end
         fre_nd_q <= emit;
         if (emit) fre_q <= {sat(acc_im_d), sat(acc_re_d)};
      end
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         dat_q <= '0;
         stb_q <= 1'b0;
         cyc_q <= 1'b0;
      end else begin
         if (acc) begin
            dat_q <= DAT_I;
            stb_q <= 1'b1;
         end else if (!halt) begin
            stb_q <= 1'b0;
         end
         if (acc)                 cyc_q <= 1'b1;
         else if (!CYC_I && !stb_q) cyc_q <= 1'b0;
      end
   end

   assign DAT_O    = dat_q;
   assign STB_O    = stb_q;
   assign WE_O     = stb_q;
   assign CYC_O    = cyc_q;
   assign FRE_O    = fre_q;
   assign FRE_O_nd = fre_nd_q;

endmodule

// File: tb/tb_fre_offset_est.sv
// Bench for fre_offset_est: constant-frame vector table, tone, stall, abort, reset and random
// frames, all checked against a sample-history reference of the autocorrelation metric.
module tb_fre_offset_est;

   localparam int DLY     = 16;
   localparam int WIN     = 16;
   localparam int EST_POS = 128;

   logic        CLK_I = 1'b0;
   logic        RST_I;
   logic [31:0] DAT_I;
   logic        WE_I, STB_I, CYC_I, ACK_I;
   logic        ACK_O, CYC_O, STB_O, WE_O, FRE_O_nd;
   logic [31:0] DAT_O, FRE_O;

   fre_offset_est #(
      .DLY     (DLY),
      .WIN     (WIN),
      .LOG2WIN (4),
      .EST_POS (EST_POS)
   ) dut (
      .CLK_I    (CLK_I),
      .RST_I    (RST_I),
      .DAT_I    (DAT_I),
      .WE_I     (WE_I),
      .STB_I    (STB_I),
      .CYC_I    (CYC_I),
      .ACK_O    (ACK_O),
      .DAT_O    (DAT_O),
      .CYC_O    (CYC_O),
      .STB_O    (STB_O),
      .WE_O     (WE_O),
      .ACK_I    (ACK_I),
      .FRE_O    (FRE_O),
      .FRE_O_nd (FRE_O_nd)
   );

   always #5 CLK_I = ~CLK_I;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state: expected stream outputs and the accepted samples of the current frame
   logic [31:0] m_dat, m_fre;
   logic        m_stb, m_cyc, m_nd;
   int          m_k;
   bit          m_done;
   int          fr_re[$];
   int          fr_im[$];
   int          nd_seen;

   typedef struct {
      logic [31:0] dat;
      logic [31:0] fre;
   } vec_t;
   vec_t vecs[5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 30)
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", nm, $time, act, exp);
      end
   endtask

   function automatic logic [15:0] sat16(input longint s);
      longint q;
      q = s >>> 20;
      if (q > 32767)  return 16'h7FFF;
      if (q < -32768) return 16'h8000;
      return 16'(q);
   endfunction

   // P over the last WIN accepted samples, lag DLY, samples before the frame counted as zero
   function automatic logic [31:0] calc_p();
      longint sre, sim, a, b, c, d;
      int n;
      sre = 0;
      sim = 0;
      n = fr_re.size() - 1;
      for (int j = n - WIN + 1; j <= n; j++) begin
         a = fr_re[j];
         b = fr_im[j];
         c = 0;
         d = 0;
         if (j >= DLY) begin
            c = fr_re[j-DLY];
            d = fr_im[j-DLY];
         end
         sre += a * c + b * d;
         sim += b * c - a * d;
      end
      return {sat16(sim), sat16(sre)};
   endfunction

   function automatic int rnd(input real x);
      return (x >= 0.0) ? $rtoi(x + 0.5) : $rtoi(x - 0.5);
   endfunction

   function automatic logic [31:0] gen(input int kind, input int idx, input logic [31:0] cval);
      real ph;
      int  re, im;
      if (kind == 0) return cval;
      if (kind == 1) begin
         ph = idx * 3.14159265358979 / 32.0;
         re = rnd(16384.0 * $cos(ph));
         im = rnd(16384.0 * $sin(ph));
         return {16'(im), 16'(re)};
      end
      return $urandom;
   endfunction

   function automatic void model_reset();
      m_dat  = '0;
      m_fre  = '0;
      m_stb  = 1'b0;
      m_cyc  = 1'b0;
      m_nd   = 1'b0;
      m_k    = 0;
      m_done = 1'b0;
      fr_re.delete();
      fr_im.delete();
   endfunction

   // Called at a negedge with inputs already driven; returns at the next negedge
   task automatic step();
      logic halt_e, acc_e;
      #1;
      halt_e = m_stb & ~ACK_I;
      acc_e  = CYC_I & STB_I & WE_I & ~halt_e;
      chk("ack_o", 32'(ACK_O), 32'(acc_e));
      @(posedge CLK_I);
      m_nd = 1'b0;
      if (acc_e) begin
         m_dat = DAT_I;
         m_cyc = 1'b1;
         fr_re.push_back(int'($signed(DAT_I[15:0])));
         fr_im.push_back(int'($signed(DAT_I[31:16])));
         m_k++;
         if (m_k == EST_POS && !m_done) begin
            m_done = 1'b1;
            m_nd   = 1'b1;
            m_fre  = calc_p();
         end
      end else if (!CYC_I && !m_stb) begin
         m_cyc = 1'b0;
      end
      if (acc_e)        m_stb = 1'b1;
      else if (!halt_e) m_stb = 1'b0;
      if (!CYC_I) begin
         m_k    = 0;
         m_done = 1'b0;
         fr_re.delete();
         fr_im.delete();
      end
      #1;
      chk("dat_o", DAT_O, m_dat);
      chk("stb_o", 32'(STB_O), 32'(m_stb));
      chk("we_o", 32'(WE_O), 32'(m_stb));
      chk("cyc_o", 32'(CYC_O), 32'(m_cyc));
      chk("fre_o", FRE_O, m_fre);
      chk("fre_nd", 32'(FRE_O_nd), 32'(m_nd));
      if (FRE_O_nd) nd_seen++;
      @(negedge CLK_I);
   endtask

   task automatic do_reset();
      RST_I = 1'b1;
      CYC_I = 1'b0;
      STB_I = 1'b0;
      WE_I  = 1'b0;
      #1;
      chk("rst_dat", DAT_O, 32'h0);
      chk("rst_stb", 32'(STB_O), 32'h0);
      chk("rst_cyc", 32'(CYC_O), 32'h0);
      chk("rst_fre", FRE_O, 32'h0);
      chk("rst_nd", 32'(FRE_O_nd), 32'h0);
      chk("rst_ack", 32'(ACK_O), 32'h0);
      model_reset();
      @(negedge CLK_I);
      RST_I = 1'b0;
   endtask

   task automatic run_frame(input int n, input int kind, input logic [31:0] cval,
                            input int stall_pct, input int gap_pct, input int stall_at,
                            input int rst_at);
      int budget, cyc;
      budget  = n * 30 + 200;
      cyc     = 0;
      nd_seen = 0;
      while (m_k < n) begin
         if (cyc >= budget) begin
            n_tests++;
            n_fail++;
            $display("FAIL frame_timeout: got %0d samples expected %0d", m_k, n);
            break;
         end
         if (rst_at > 0 && m_k == rst_at) begin
            do_reset();
            break;
         end
         CYC_I = 1'b1;
         WE_I  = (kind == 2) ? ($urandom_range(0, 9) != 0) : 1'b1;
         STB_I = ($urandom_range(0, 99) >= gap_pct);
         ACK_I = ($urandom_range(0, 99) >= stall_pct);
         if (stall_at > 0 && cyc >= stall_at && cyc < stall_at + 10) ACK_I = 1'b0;
         DAT_I = gen(kind, m_k, cval);
         step();
         cyc++;
      end
      CYC_I = 1'b0;
      STB_I = 1'b0;
      WE_I  = 1'b0;
      ACK_I = 1'b1;
      repeat (4) step();
   endtask

   initial begin
      logic signed [15:0] fre_re, fre_im;
      vecs[0] = '{dat: 32'h0000_4000, fre: 32'h0000_1000};
      vecs[1] = '{dat: 32'h8000_8000, fre: 32'h0000_7FFF};
      vecs[2] = '{dat: 32'hC000_0000, fre: 32'h0000_1000};
      vecs[3] = '{dat: 32'h0000_7FFF, fre: 32'h0000_3FFF};
      vecs[4] = '{dat: 32'h0000_8000, fre: 32'h0000_4000};

      RST_I = 1'b1;
      DAT_I = '0;
      WE_I  = 1'b0;
      STB_I = 1'b0;
      CYC_I = 1'b0;
      ACK_I = 1'b1;
      model_reset();
      repeat (2) @(negedge CLK_I);
      do_reset();

      for (int i = 0; i < 5; i++) begin
         run_frame(200, 0, vecs[i].dat, 0, 0, 0, 0);
         chk("vec_fre", FRE_O, vecs[i].fre);
         chk("vec_nd_count", nd_seen, 1);
      end

      run_frame(200, 1, '0, 0, 0, 0, 0);
      fre_re = FRE_O[15:0];
      fre_im = FRE_O[31:16];
      n_tests++;
      if (fre_re > 2 || fre_re < -2 || fre_im > 16'sh1002 || fre_im < 16'sh0FFE) begin
         n_fail++;
         $display("FAIL tone_fre: got 0x%08h expected 0x10000000 +/-2", FRE_O);
      end

      run_frame(200, 0, 32'h0000_4000, 0, 0, 60, 0);
      chk("halt_fre", FRE_O, 32'h0000_1000);
      chk("halt_nd_count", nd_seen, 1);

      run_frame(100, 0, 32'h0000_4000, 0, 0, 0, 0);
      chk("abort_nd_count", nd_seen, 0);
      chk("abort_fre_hold", FRE_O, 32'h0000_1000);
      run_frame(200, 0, 32'h0000_4000, 0, 0, 0, 0);
      chk("after_abort_fre", FRE_O, 32'h0000_1000);
      chk("after_abort_nd", nd_seen, 1);

      run_frame(200, 0, 32'h0000_4000, 0, 0, 0, 60);
      chk("rst_mid_nd", nd_seen, 0);
      run_frame(200, 0, 32'h0000_4000, 0, 0, 0, 0);
      chk("after_rst_fre", FRE_O, 32'h0000_1000);
      chk("after_rst_nd", nd_seen, 1);

      for (int f = 0; f < 6; f++) begin
         run_frame(int'($urandom_range(130, 200)), 2, '0, 30, 20, 0, 0);
         chk("rand_nd_count", nd_seen, 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
